// File: rtl/bus_fifo_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_fifo_target                                                |
// | Brief   : Main-bus target exposing a TX/RX FIFO mailbox to local streams. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bus_fifo_target #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  select_i,
  input  logic                  rw_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_strobe_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  irq_o
);

  localparam int                c_aw        = $clog2(DEPTH);
  localparam int                c_cw        = c_aw + 1;
  localparam logic [c_aw-1:0]   c_ptr_one   = c_aw'(1);
  localparam logic [c_cw-1:0]   c_cnt_one   = c_cw'(1);
  localparam logic [c_cw-1:0]   c_cnt_full  = c_cw'(DEPTH);
  localparam logic [1:0]        c_addr_data = 2'd0;
  localparam logic [1:0]        c_addr_stat = 2'd1;
  localparam logic [1:0]        c_addr_ctrl = 2'd2;
  localparam logic [1:0]        c_addr_txc  = 2'd3;

  logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [c_aw-1:0]       r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
  logic [c_cw-1:0]       r_tx_count, r_rx_count;
  logic                  r_tx_ovf, r_rx_udf;
  logic [DATA_WIDTH-1:0] r_data_o;

  logic w_acc, w_wr, w_rd;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_ctrl_wr, w_tx_flush, w_rx_flush, w_clr_sticky;
  logic w_tx_push_req, w_tx_push, w_tx_pop, w_ovf_set;
  logic w_rx_pop_req, w_rx_pop, w_rx_push, w_udf_set;
  logic [DATA_WIDTH-1:0] w_rx_head, w_status, w_rd_mux;

  assign w_acc = select_i & data_strobe_i;
  assign w_wr  = w_acc & rw_i;
  assign w_rd  = w_acc & ~rw_i;

  assign w_tx_full  = (r_tx_count == c_cnt_full);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == c_cnt_full);
  assign w_rx_empty = (r_rx_count == '0);

  assign w_ctrl_wr    = w_wr & (addr_i == c_addr_ctrl);
  assign w_tx_flush   = w_ctrl_wr & data_i[0];
  assign w_rx_flush   = w_ctrl_wr & data_i[1];
  assign w_clr_sticky = w_ctrl_wr & data_i[2];

  // Full/empty come from the registered counts, so a same-cycle pop never frees room for a push.
  assign w_tx_push_req = w_wr & (addr_i == c_addr_data);
  assign w_tx_push     = w_tx_push_req & ~w_tx_full & ~w_tx_flush;
  assign w_ovf_set     = w_tx_push_req & w_tx_full;
  assign w_tx_pop      = ~w_tx_empty & tx_ready_i & ~w_tx_flush;

  assign w_rx_pop_req = w_rd & (addr_i == c_addr_data);
  assign w_rx_pop     = w_rx_pop_req & ~w_rx_empty & ~w_rx_flush;
  assign w_udf_set    = w_rx_pop_req & w_rx_empty;
  assign w_rx_push    = rx_valid_i & ~w_rx_full & ~w_rx_flush;

  assign w_rx_head  = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
  assign tx_data_o  = w_tx_empty ? '0 : r_tx_mem[r_tx_rd_ptr];
  assign tx_valid_o = ~w_tx_empty;
  assign rx_ready_o = ~w_rx_full;
  assign irq_o      = ~w_rx_empty | r_tx_ovf | r_rx_udf;
  assign data_o     = r_data_o;

  always_comb begin
    w_status       = '0;
    w_status[15]   = w_tx_full;
    w_status[14]   = w_tx_empty;
    w_status[13]   = w_rx_full;
    w_status[12]   = w_rx_empty;
    w_status[11]   = r_tx_ovf;
    w_status[10]   = r_rx_udf;
    w_status[7:0]  = 8'(r_rx_count);
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr_i)
      c_addr_data: w_rd_mux = w_rx_head;
      c_addr_stat: w_rd_mux = w_status;
      c_addr_txc:  w_rd_mux[7:0] = 8'(r_tx_count);
      default:     w_rd_mux = '0;
    endcase
  end

  // Storage arrays carry no reset; the empty flags mask their contents.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= data_i;
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_tx_ovf    <= 1'b0;
      r_rx_udf    <= 1'b0;
      r_data_o    <= '0;
    end else begin
      if (w_tx_flush) begin
        r_tx_wr_ptr <= '0;
        r_tx_rd_ptr <= '0;
        r_tx_count  <= '0;
      end else begin
        if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + c_ptr_one;
        if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + c_ptr_one;
        case ({w_tx_push, w_tx_pop})
          2'b10:   r_tx_count <= r_tx_count + c_cnt_one;
          2'b01:   r_tx_count <= r_tx_count - c_cnt_one;
          default: r_tx_count <= r_tx_count;
        endcase
      end

      if (w_rx_flush) begin
        r_rx_wr_ptr <= '0;
        r_rx_rd_ptr <= '0;
        r_rx_count  <= '0;
      end else begin
        if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + c_ptr_one;
        if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + c_ptr_one;
        case ({w_rx_push, w_rx_pop})
          2'b10:   r_rx_count <= r_rx_count + c_cnt_one;
          2'b01:   r_rx_count <= r_rx_count - c_cnt_one;
          default: r_rx_count <= r_rx_count;
        endcase
      end

      // A new event wins over a simultaneous clear.
      r_tx_ovf <= (r_tx_ovf & ~w_clr_sticky) | w_ovf_set;
      r_rx_udf <= (r_rx_udf & ~w_clr_sticky) | w_udf_set;
      r_data_o <= (select_i & ~rw_i) ? w_rd_mux : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_fifo_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bus_fifo_target                                             |
// | Brief   : Directed and random checks of bus_fifo_target vs a queue model.|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bus_fifo_target;
  localparam int DEPTH = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        select_i = 1'b0, rw_i = 1'b0, data_strobe_i = 1'b0;
  logic        tx_ready_i = 1'b0, rx_valid_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [15:0] data_i = 16'h0, rx_data_i = 16'h0;
  logic [15:0] data_o, tx_data_o;
  logic        tx_valid_o, rx_ready_o, irq_o;

  bus_fifo_target #(.DEPTH(DEPTH), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .select_i(select_i), .rw_i(rw_i),
    .addr_i(addr_i), .data_i(data_i), .data_strobe_i(data_strobe_i),
    .data_o(data_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] tq[$];
  logic [15:0] rq[$];
  bit ovf = 1'b0, udf = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0: return (rq.size() != 0) ? rq[0] : 16'h0;
      2'd1: return {tq.size() == DEPTH, tq.size() == 0, rq.size() == DEPTH, rq.size() == 0,
                    ovf, udf, 2'b00, 8'(rq.size())};
      2'd3: return 16'(tq.size());
      default: return 16'h0;
    endcase
  endfunction

  // One clock: apply the mailbox rules to the model, then compare all outputs.
  task automatic cycle();
    logic [15:0] exp_d;
    bit wr, rd, txf, txe, rxf, rxe, fl_t, fl_r, clr;
    exp_d = (select_i && !rw_i) ? model_reg(addr_i) : 16'h0;
    txf = (tq.size() == DEPTH); txe = (tq.size() == 0);
    rxf = (rq.size() == DEPTH); rxe = (rq.size() == 0);
    wr = select_i && data_strobe_i && rw_i;
    rd = select_i && data_strobe_i && !rw_i;
    fl_t = wr && addr_i == 2 && data_i[0];
    fl_r = wr && addr_i == 2 && data_i[1];
    clr  = wr && addr_i == 2 && data_i[2];
    ovf = (ovf && !clr) || (wr && addr_i == 0 && txf);
    udf = (udf && !clr) || (rd && addr_i == 0 && rxe);
    if (fl_t) tq.delete();
    else begin
      if (!txe && tx_ready_i) void'(tq.pop_front());
      if (wr && addr_i == 0 && !txf) tq.push_back(data_i);
    end
    if (fl_r) rq.delete();
    else begin
      if (rd && addr_i == 0 && !rxe) void'(rq.pop_front());
      if (rx_valid_i && !rxf) rq.push_back(rx_data_i);
    end
    @(posedge clk); #1;
    chk("data_o", data_o, exp_d);
    chk("tx_valid", {15'h0, tx_valid_o}, {15'h0, tq.size() != 0});
    chk("tx_data", tx_data_o, (tq.size() != 0) ? tq[0] : 16'h0);
    chk("rx_ready", {15'h0, rx_ready_o}, {15'h0, rq.size() != DEPTH});
    chk("irq", {15'h0, irq_o}, {15'h0, (rq.size() != 0) || ovf || udf});
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    select_i = 1; rw_i = 1; addr_i = a; data_i = d; data_strobe_i = 1;
    cycle();
    select_i = 0; rw_i = 0; data_strobe_i = 0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] v);
    select_i = 1; rw_i = 0; addr_i = a; data_strobe_i = 0;
    cycle();
    data_strobe_i = 1; v = data_o;
    cycle();
    select_i = 0; data_strobe_i = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; #3;
    tq.delete(); rq.delete(); ovf = 0; udf = 0;
    chk("rst_data_o", data_o, 16'h0);
    chk("rst_tx_valid", {15'h0, tx_valid_o}, 16'h0);
    chk("rst_tx_data", tx_data_o, 16'h0);
    chk("rst_rx_ready", {15'h0, rx_ready_o}, 16'h1);
    chk("rst_irq", {15'h0, irq_o}, 16'h0);
    select_i = 0; data_strobe_i = 0; rw_i = 0; tx_ready_i = 0; rx_valid_i = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] exp_tx [3];
    exp_tx[0] = 16'h1111; exp_tx[1] = 16'h2222; exp_tx[2] = 16'h3333;

    do_reset();
    bus_rd(2'd1, v);
    chk("t1_status", v, 16'h5000);
    chk("t1_rx_ready", {15'h0, rx_ready_o}, 16'h1);
    chk("t1_tx_valid", {15'h0, tx_valid_o}, 16'h0);

    for (int i = 0; i < 3; i++) bus_wr(2'd0, exp_tx[i]);
    bus_rd(2'd3, v);
    chk("t2_txcount", v, 16'd3);
    tx_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stream", tx_data_o, exp_tx[i]);
      cycle();
    end
    chk("t2_drained", {15'h0, tx_valid_o}, 16'h0);
    tx_ready_i = 0;

    for (int i = 0; i < 17; i++) bus_wr(2'd0, 16'(i + 16'h100));
    bus_rd(2'd3, v);
    chk("t3_txcount", v, 16'd16);
    bus_rd(2'd1, v);
    chk("t3_txfull", {15'h0, v[15]}, 16'h1);
    chk("t3_ovf", {15'h0, v[11]}, 16'h1);
    bus_wr(2'd2, 16'h4);
    bus_rd(2'd1, v);
    chk("t3_ovf_clr", {15'h0, v[11]}, 16'h0);
    bus_wr(2'd2, 16'h1);

    rx_valid_i = 1; rx_data_i = 16'hA5A5; cycle();
    rx_data_i = 16'h5A5A; cycle();
    rx_valid_i = 0;
    bus_rd(2'd1, v);
    chk("t4_rxcount", {8'h0, v[7:0]}, 16'd2);
    chk("t4_irq", {15'h0, irq_o}, 16'h1);
    bus_rd(2'd0, v); chk("t4_rd1", v, 16'hA5A5);
    bus_rd(2'd0, v); chk("t4_rd2", v, 16'h5A5A);
    bus_rd(2'd0, v); chk("t4_rd3", v, 16'h0);
    bus_rd(2'd1, v);
    chk("t4_udf", {15'h0, v[10]}, 16'h1);
    bus_wr(2'd2, 16'h4);

    rx_valid_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data_i = 16'((i + 1) * 16'h0101);
      cycle();
    end
    rx_valid_i = 0;
    chk("t5_rx_full", {15'h0, rx_ready_o}, 16'h0);
    select_i = 1; rw_i = 0; addr_i = 2'd0; data_strobe_i = 0;
    cycle();
    data_strobe_i = 1; rx_valid_i = 1; rx_data_i = 16'hDEAD; v = data_o;
    cycle();
    select_i = 0; data_strobe_i = 0; rx_valid_i = 0;
    chk("t5_head", v, 16'h0101);
    bus_rd(2'd1, v);
    chk("t5_rxcount", {8'h0, v[7:0]}, 16'd15);

    for (int i = 0; i < 5; i++) bus_wr(2'd0, 16'(16'h700 + i));
    bus_rd(2'd3, v);
    chk("t6_txcount5", v, 16'd5);
    tx_ready_i = 1;
    bus_wr(2'd2, 16'h1);
    chk("t6_tx_valid", {15'h0, tx_valid_o}, 16'h0);
    tx_ready_i = 0;
    bus_rd(2'd3, v);
    chk("t6_txcount0", v, 16'd0);
    bus_rd(2'd1, v);
    chk("t6_rx_kept", {8'h0, v[7:0]}, 16'd15);

    for (int i = 0; i < 1500; i++) begin
      select_i      = 1'($urandom);
      rw_i          = 1'($urandom);
      addr_i        = 2'($urandom);
      data_i        = 16'($urandom);
      data_strobe_i = ($urandom_range(0, 3) == 0);
      tx_ready_i    = ($urandom_range(0, 2) == 0);
      rx_valid_i    = 1'($urandom);
      rx_data_i     = 16'($urandom);
      cycle();
    end

    select_i = 1; rw_i = 1; addr_i = 2'd0; data_strobe_i = 1; rx_valid_i = 1;
    do_reset();
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
